axi4_write_master: RTL and testbench
====================================

// Module: axi4_write_master
// PURPOSE
// - Command-driven AXI4 write-burst master; sits directly upstream of the axi4 slave and drives its AW/W/B channels.
// - Accepts one burst command (addr, len) and a beat stream; issues AW, streams W beats with WLAST, collects BRESP.
// - Reports completion and response to the command source; one burst outstanding at a time.
// PARAMETERS
// - DATA_WIDTH      32    width of WDATA and of the beat stream
// - ADDR_WIDTH      10    width of AWADDR / cmd_addr
// - TIMEOUT_CYCLES  256   B-channel watchdog limit in cycles; used only with AXI_WM_TIMEOUT_EN
// PORTS
// - ACLK         in   1           clock, all logic on rising edge
// - ARESETn      in   1           asynchronous active-low reset
// - cmd_valid    in   1           burst command valid
// - cmd_ready    out  1           command accepted when cmd_valid & cmd_ready
// - cmd_addr     in   ADDR_WIDTH  burst start address
// - cmd_len      in   8           beats-1, AXI4 AWLEN encoding
// - wd_valid     in   1           write-beat stream valid
// - wd_ready     out  1           write-beat stream ready
// - wd_data      in   DATA_WIDTH  write-beat data
// - done_valid   out  1           one-cycle pulse when burst completes
// - done_resp    out  2           BRESP of completed burst, or 2'b10 on timeout
// - AWADDR       out  ADDR_WIDTH  write address
// - AWLEN        out  8           write burst length
// - AWSIZE       out  3           fixed $clog2(DATA_WIDTH/8); 3'b010 for 32 bits
// - AWVALID      out  1           address valid
// - AWREADY      in   1           address ready
// - WDATA        out  DATA_WIDTH  write data, wd_data passed through
// - WLAST        out  1           last beat of burst
// - WVALID       out  1           write data valid
// - WREADY       in   1           write data ready
// - BRESP        in   2           write response
// - BVALID       in   1           response valid
// - BREADY       out  1           response ready
// BEHAVIOUR
// - Reset: FSM=IDLE; AWVALID, WVALID, WLAST, BREADY, done_valid = 0; AWADDR, AWLEN = 0; done_resp = 2'b00; beat_cnt = 0.
// - Reset mid-burst: all valids drop asynchronously; the partial burst is abandoned and not reported.
// - FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE.
// - IDLE: cmd_ready = 1; on cmd_valid, latch addr/len into AWADDR/AWLEN and go to ADDR.
//   AWVALID rises the cycle after acceptance.
// - ADDR: AWVALID = 1; AWADDR, AWLEN stable until AWREADY. On AWVALID & AWREADY, go to DATA; beat_cnt = 0.
// - DATA: WVALID = wd_valid; wd_ready = WREADY; WDATA = wd_data; WLAST = (beat_cnt == AWLEN).
// - DATA: beat_cnt increments on each WVALID & WREADY; the WLAST handshake moves to RESP.
// - DATA: W is never issued before the AW handshake; bubbles on wd_valid are allowed.
// - RESP: BREADY = 1; on BVALID, done_valid pulses 1 cycle with done_resp = BRESP; back to IDLE.
// - A new command can be accepted the cycle after done_valid.
// - cmd_ready = 0 outside IDLE, so commands presented while busy stall; they are never dropped.
// - wd_ready = 0 outside DATA, so beats are never consumed early.
// - AWLEN = 0: single beat with WLAST = 1 on that beat. AWLEN = 255: 256 beats; beat_cnt is 8 bits and never wraps within a burst.
// - BVALID outside RESP is ignored, with BREADY held 0.
// - Min latency with all readies high: accept N, AW N+1, W N+2..N+2+len, B at the earliest next cycle.
// CONFIGURATION
// - AXI_WM_TIMEOUT_EN defined:
//   - a 16-bit counter runs in RESP and clears on entry.
//   - On reaching TIMEOUT_CYCLES without BVALID: done_valid pulses with done_resp = 2'b10, BREADY drops, FSM -> IDLE.
// - AXI_WM_TIMEOUT_EN undefined: no counter; RESP waits indefinitely for BVALID.
// TESTING
// - Single beat: cmd addr=0x010, len=0, data 0xDEADBEEF, all readies 1 -> AWLEN=0, one W beat with WLAST=1, done_resp=00.
// - 4-beat burst: addr=0x100, len=3, data 1..4, WREADY toggling 1/0 -> exactly 4 W handshakes; WLAST only on data 4.
// - AWREADY held 0 for 5 cycles -> AWVALID and AWADDR stay stable 5 cycles; no WVALID before the AW handshake.
// - BRESP=2'b10 (SLVERR) from slave -> done_resp=2'b10; second command in the same cycle accepted only after done.
// - ARESETn low during beat 2 of len=7 -> all valids 0; after release, a new len=1 burst completes with done_resp=00.
// - AXI_WM_TIMEOUT_EN with TIMEOUT_CYCLES=16 and BVALID never high -> done_valid plus 2'b10 exactly 16 cycles after RESP entry.

Source files
------------

// File: rtl/axi4_write_master.sv
// -----------------------------------------------------------------------------
// axi4_write_master
//
// Command-driven AXI4 write-burst master. Takes one burst command (start
// address + AWLEN-encoded length) and a stream of write beats, issues the AW
// request, streams the beats on W with WLAST on the final one, collects the
// B response and reports it back to the command source. Only one burst is
// in flight at a time.
//
// Optional feature macro: AXI_WM_TIMEOUT_EN
//   defined   : B-channel watchdog. If no BVALID arrives within
//               TIMEOUT_CYCLES cycles of entering the response phase, the
//               burst completes with done_resp = 2'b10.
//   undefined : the response phase waits indefinitely for BVALID.
//
// Handshakes: every channel follows valid/ready semantics. A transfer happens
// on a rising ACLK edge where both valid and ready are high; a valid, once
// raised, stays high with stable payload until that transfer.
//
// Ports
//   ACLK, ARESETn          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    burst command handshake
//   cmd_addr, cmd_len      burst start address, beats-1
//   wd_valid/wd_ready      write-beat stream handshake
//   wd_data                write-beat payload
//   done_valid, done_resp  one-cycle completion pulse and its response
//   AWADDR..AWREADY        AXI4 write-address channel
//   WDATA..WREADY          AXI4 write-data channel
//   BRESP, BVALID, BREADY  AXI4 write-response channel
// -----------------------------------------------------------------------------
module axi4_write_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // command source
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    // write-beat stream
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    // completion report
    output logic                  done_valid,
    output logic [1:0]            done_resp,
    // AXI4 write-address channel
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    // AXI4 write-data channel
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    // AXI4 write-response channel
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    // The watchdog counter is 16 bits wide and fires one cycle before the
    // limit is reached, so the limit has to fit in 1..65536.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("axi4_write_master: TIMEOUT_CYCLES must be in 1..65536");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // state is kept as a named signal so checkers can bind to it directly.
    state_t     state;
    state_t     state_nxt;
    logic [7:0] beat_cnt;
    logic       last_beat;
    logic       timeout_hit;

    assign AWSIZE    = 3'($clog2(DATA_WIDTH / 8));
    assign WDATA     = wd_data;
    assign last_beat = (beat_cnt == AWLEN);

`ifdef AXI_WM_TIMEOUT_EN
    // Held at zero outside RESP, so it reads 0 in the first RESP cycle and
    // TIMEOUT_CYCLES-1 in the last cycle before the watchdog fires.
    logic [15:0] tmo_cnt;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tmo_cnt <= '0;
        end else if (state != S_RESP) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == S_RESP) && !BVALID &&
                         (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and channel controls. All valids/readies are decoded from
    // state, so an asynchronous reset drops them immediately.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wd_ready  = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        WLAST     = 1'b0;
        BREADY    = 1'b0;
        case (state)
            S_IDLE: begin
                // Holding off during the done pulse makes the earliest new
                // acceptance the cycle after completion is reported.
                cmd_ready = !done_valid;
                if (cmd_valid && !done_valid) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                AWVALID = 1'b1;
                if (AWREADY) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                WVALID   = wd_valid;
                wd_ready = WREADY;
                WLAST    = last_beat;
                if (wd_valid && WREADY && last_beat) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                BREADY = 1'b1;
                if (BVALID || timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command latch, beat counter and completion report
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            AWADDR     <= '0;
            AWLEN      <= '0;
            beat_cnt   <= '0;
            done_valid <= 1'b0;
            done_resp  <= 2'b00;
        end else begin
            done_valid <= 1'b0;

            if (state == S_IDLE && cmd_valid && cmd_ready) begin
                AWADDR <= cmd_addr;
                AWLEN  <= cmd_len;
            end

            // The counter stops on the final beat rather than stepping past
            // AWLEN, so a 256-beat burst never wraps it.
            if (state == S_ADDR && AWREADY) begin
                beat_cnt <= '0;
            end else if (state == S_DATA && wd_valid && WREADY && !last_beat) begin
                beat_cnt <= beat_cnt + 8'd1;
            end

            if (state == S_RESP && BVALID) begin
                done_valid <= 1'b1;
                done_resp  <= BRESP;
            end else if (timeout_hit) begin
                done_valid <= 1'b1;
                done_resp  <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_axi4_write_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_write_master
//
// Directed bench for axi4_write_master: single beat with latency, 4-beat burst
// under WREADY throttling with stray BVALID, AW back-pressure, SLVERR with a
// queued second command, reset mid-burst, a 256-beat burst and the response
// wait / watchdog (selected by AXI_WM_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_axi4_write_master;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int EW = DW + 1;   // {last, data}

    // ---------------- clock / reset ----------------
    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    // ---------------- DUT ----------------
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic [AW-1:0] AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic          AWVALID, AWREADY;
    logic [DW-1:0] WDATA;
    logic          WLAST, WVALID, WREADY;
    logic [1:0]    BRESP;
    logic          BVALID, BREADY;

    axi4_write_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .done_valid(done_valid),
        .done_resp (done_resp),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0]   exp_q[$];    // expected W beats {last, data}
    logic [AW+7:0]   aw_q[$];     // expected AW {addr, len}
    logic [1:0]      resp_q[$];   // expected done_resp
    logic [DW-1:0]   src_q[$];    // beats the source still has to offer

    int aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, done_cnt = 0, acc_cnt = 0;
    int acc_cyc = 0, aw_cyc = 0, w_first_cyc = 0, w_last_cyc = 0;
    int done_cyc = 0, resp_entry_cyc = 0, aw_stall_seen = 0;
    bit aw_done = 1'b0, w_first_pending = 1'b0, bready_q = 1'b0, src_fire = 1'b0;
    logic [EW-1:0] e;

    // slave behaviour knobs
    int         aw_stall = 0;
    int         b_delay  = 0;
    bit         wready_toggle = 1'b0;
    bit         b_never = 1'b0;
    bit         b_force = 1'b0;
    logic [1:0] bresp_val = 2'b00;
    int         aw_wait = 0, b_wait = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- monitor (samples on falling edge) ----------------
    always @(negedge ACLK) begin
        src_fire = wd_valid && wd_ready;
        if (!ARESETn) begin
            bready_q = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (AWVALID) begin
                check("w_during_aw", WVALID, 0);
                if (aw_q.size() > 0) begin
                    check("awaddr", AWADDR, aw_q[0][AW+7:8]);
                    check("awlen", AWLEN, aw_q[0][7:0]);
                end else begin
                    check("aw_unexpected", 1, 0);
                end
                if (!AWREADY) begin
                    aw_stall_seen++;
                end else begin
                    if (aw_q.size() > 0) void'(aw_q.pop_front());
                    aw_cnt++;
                    aw_cyc = cyc;
                    aw_done = 1'b1;
                    w_first_pending = 1'b1;
                end
            end
            if (WVALID && WREADY) begin
                check("w_after_aw", aw_done, 1);
                if (w_first_pending) begin
                    w_first_cyc = cyc;
                    w_first_pending = 1'b0;
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wdata", WDATA, e[DW-1:0]);
                    check("wlast", WLAST, e[DW]);
                end else begin
                    check("w_unexpected", 1, 0);
                end
                w_cnt++;
                if (WLAST) begin
                    wlast_cnt++;
                    w_last_cyc = cyc;
                    aw_done = 1'b0;
                end
            end
            if (BREADY && !bready_q) resp_entry_cyc = cyc;
            bready_q = BREADY;
            if (done_valid) begin
                done_cnt++;
                done_cyc = cyc;
                if (resp_q.size() > 0) check("done_resp", done_resp, resp_q.pop_front());
                else check("done_unexpected", 1, 0);
            end
        end
    end

    // ---------------- beat source driver ----------------
    initial begin
        wd_valid = 1'b0;
        wd_data  = '0;
        forever begin
            @(posedge ACLK);
            if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
            #1;
            wd_valid = (src_q.size() > 0);
            wd_data  = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    // ---------------- AXI slave driver ----------------
    initial begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BRESP   = 2'b00;
        forever begin
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                aw_wait = 0;
                b_wait  = 0;
                AWREADY = 1'b0;
                WREADY  = 1'b0;
                BVALID  = b_force;
            end else begin
                if (AWVALID) begin
                    AWREADY = (aw_wait >= aw_stall);
                    aw_wait++;
                end else begin
                    AWREADY = 1'b0;
                    aw_wait = 0;
                end
                WREADY = wready_toggle ? ~WREADY : 1'b1;
                if (BREADY) begin
                    BVALID = b_force || (!b_never && b_wait >= b_delay);
                    b_wait++;
                end else begin
                    BVALID = b_force;
                    b_wait = 0;
                end
                BRESP = bresp_val;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic queue_burst(input logic [AW-1:0] addr, input int len,
                               input logic [DW-1:0] d0, input logic [DW-1:0] step,
                               input logic [1:0] resp);
        logic [DW-1:0] d;
        aw_q.push_back({addr, 8'(len)});
        for (int i = 0; i <= len; i++) begin
            d = d0 + step * DW'(i);
            src_q.push_back(d);
            exp_q.push_back({(i == len), d});
        end
        resp_q.push_back(resp);
    endtask

    task automatic send_cmd(input logic [AW-1:0] addr, input logic [7:0] len);
        bit ok = 1'b0;
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int k = 0; k < 400; k++) begin
            @(negedge ACLK);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cmd_accept_timeout", 0, 1);
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_cnt >= target) break;
            @(negedge ACLK);
            #1;
        end
        repeat (3) @(negedge ACLK);
        #1;
        check("done_count", done_cnt, target);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    int d0, w0, a0, l0;

    initial begin
        ARESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;

        // reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awvalid", AWVALID, 0);
        check("rst_wvalid", WVALID, 0);
        check("rst_wlast", WLAST, 0);
        check("rst_bready", BREADY, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_awaddr", AWADDR, 0);
        check("rst_awlen", AWLEN, 0);
        check("rst_done_resp", done_resp, 0);
        check("rst_wd_ready", wd_ready, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("awsize", AWSIZE, 3'b010);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;

        // single beat, all readies high, minimum latency
        d0 = done_cnt; w0 = w_cnt; a0 = aw_cnt;
        queue_burst(10'h010, 0, 32'hDEADBEEF, 32'h0, 2'b00);
        send_cmd(10'h010, 8'd0);
        wait_done(d0 + 1, 50);
        check("t1_aw_count", aw_cnt - a0, 1);
        check("t1_w_count", w_cnt - w0, 1);
        check("t1_lat_aw", aw_cyc - acc_cyc, 1);
        check("t1_lat_w", w_first_cyc - acc_cyc, 2);
        check("t1_lat_resp", resp_entry_cyc - acc_cyc, 3);
        check("t1_lat_done", done_cyc - acc_cyc, 4);

        // 4 beats, WREADY toggling, BVALID stuck high outside RESP
        wready_toggle = 1'b1;
        b_force = 1'b1;
        d0 = done_cnt; w0 = w_cnt; l0 = wlast_cnt;
        queue_burst(10'h100, 3, 32'd1, 32'd1, 2'b00);
        send_cmd(10'h100, 8'd3);
        wait_done(d0 + 1, 100);
        check("t2_w_count", w_cnt - w0, 4);
        check("t2_wlast_count", wlast_cnt - l0, 1);
        check("t2_done_after_wlast", done_cyc - w_last_cyc, 2);
        wready_toggle = 1'b0;
        b_force = 1'b0;

        // AWREADY held low for 5 cycles
        aw_stall = 5;
        aw_stall_seen = 0;
        d0 = done_cnt; w0 = w_cnt;
        queue_burst(10'h2A4, 1, 32'hA5A50000, 32'd1, 2'b00);
        send_cmd(10'h2A4, 8'd1);
        wait_done(d0 + 1, 100);
        check("t3_aw_stall_cycles", aw_stall_seen, 5);
        check("t3_w_count", w_cnt - w0, 2);
        aw_stall = 0;

        // SLVERR, second command waits for completion
        bresp_val = 2'b10;
        b_delay = 3;
        d0 = done_cnt; a0 = acc_cnt;
        queue_burst(10'h044, 0, 32'h11111111, 32'h0, 2'b10);
        queue_burst(10'h048, 0, 32'h22222222, 32'h0, 2'b10);
        send_cmd(10'h044, 8'd0);
        send_cmd(10'h048, 8'd0);
        check("t4_first_done_before_second", done_cnt - d0, 1);
        check("t4_accept_after_done", acc_cyc - done_cyc, 1);
        wait_done(d0 + 2, 100);
        check("t4_accept_count", acc_cnt - a0, 2);
        bresp_val = 2'b00;
        b_delay = 0;

        // reset asserted during beat 2 of an 8-beat burst
        d0 = done_cnt; w0 = w_cnt;
        queue_burst(10'h300, 7, 32'h100, 32'd1, 2'b00);
        send_cmd(10'h300, 8'd7);
        for (int k = 0; k < 50; k++) begin
            if (w_cnt - w0 >= 2) break;
            @(negedge ACLK);
            #1;
        end
        check("t5_two_beats_before_reset", w_cnt - w0, 2);
        @(posedge ACLK);
        #2;
        ARESETn = 1'b0;
        #1;
        check("t5_rst_awvalid", AWVALID, 0);
        check("t5_rst_wvalid", WVALID, 0);
        check("t5_rst_wlast", WLAST, 0);
        check("t5_rst_bready", BREADY, 0);
        check("t5_rst_wd_ready", wd_ready, 0);
        aw_q.delete();
        exp_q.delete();
        src_q.delete();
        resp_q.delete();
        aw_done = 1'b0;
        w_first_pending = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        check("t5_abandoned_not_reported", done_cnt - d0, 0);
        w0 = w_cnt;
        queue_burst(10'h0F0, 1, 32'hCAFE0000, 32'd1, 2'b00);
        send_cmd(10'h0F0, 8'd1);
        wait_done(d0 + 1, 100);
        check("t5_w_count_after_reset", w_cnt - w0, 2);

        // 256-beat burst
        d0 = done_cnt; w0 = w_cnt; l0 = wlast_cnt;
        queue_burst(10'h3F0, 255, 32'h5000, 32'd3, 2'b00);
        send_cmd(10'h3F0, 8'd255);
        wait_done(d0 + 1, 600);
        check("t6_w_count", w_cnt - w0, 256);
        check("t6_wlast_count", wlast_cnt - l0, 1);

        // response never arrives
        b_never = 1'b1;
        d0 = done_cnt;
`ifdef AXI_WM_TIMEOUT_EN
        queue_burst(10'h020, 0, 32'h77, 32'h0, 2'b10);
        send_cmd(10'h020, 8'd0);
        wait_done(d0 + 1, 100);
        check("t7_timeout_latency", done_cyc - resp_entry_cyc, 16);
        check("t7_bready_dropped", BREADY, 0);
        b_never = 1'b0;
`else
        queue_burst(10'h020, 0, 32'h77, 32'h0, 2'b00);
        send_cmd(10'h020, 8'd0);
        repeat (40) @(negedge ACLK);
        #1;
        check("t7_no_done_while_waiting", done_cnt - d0, 0);
        check("t7_bready_held", BREADY, 1);
        b_never = 1'b0;
        wait_done(d0 + 1, 20);
`endif

        check("end_exp_q_empty", exp_q.size(), 0);
        check("end_resp_q_empty", resp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
